// File: rtl/sigmon_event_recorder.sv
// Event recorder for up to four sigmon pattern units: per-unit pending slots,
// a lowest-index-first arbiter and a FWFT record FIFO with drop/event statistics.
module sigmon_event_recorder #(
  parameter int FIFO_AW      = 4,
  parameter int NUM_PATTERNS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear,
  input  logic [3:0]         match_event,
  input  logic [3:0]         sample_event,
  input  logic [3:0]         merged_event,
  input  logic [191:0]       sample_data,
  output logic               rec_valid,
  input  logic               rec_ready,
  output logic [95:0]        rec_data,
  output logic [FIFO_AW:0]   fifo_count,
  output logic [15:0]        drop_count,
  output logic [31:0]        event_count
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [31:0]             ts;
  logic [7:0]              seq;
  logic [NUM_PATTERNS-1:0] pend_valid;
  logic [2:0]              pend_type [NUM_PATTERNS];
  logic [47:0]             pend_data [NUM_PATTERNS];
  logic [31:0]             pend_ts   [NUM_PATTERNS];

  logic [NUM_PATTERNS-1:0] new_ev;
  logic [NUM_PATTERNS-1:0] grant;
  logic [NUM_PATTERNS-1:0] load;
  logic [NUM_PATTERNS-1:0] drop_vec;
  logic                    push;
  logic                    pop;
  logic                    full;
  logic [1:0]              push_id;
  logic [95:0]             push_rec;
  logic [2:0]              drop_inc;
  logic [16:0]             drop_sum;

  logic [95:0]             mem [DEPTH];
  logic [FIFO_AW-1:0]      wr_ptr;
  logic [FIFO_AW-1:0]      rd_ptr;

  // Stream handshake: a record transfers on any edge where rec_valid and
  // rec_ready are both high; rec_valid never waits on rec_ready, and the head
  // record stays on rec_data until that transfer happens.
  assign full      = fifo_count[FIFO_AW];
  assign rec_valid = (fifo_count != '0);
  assign pop       = rec_valid & rec_ready;
  assign rec_data  = rec_valid ? mem[rd_ptr] : '0;

  always_comb begin
    push_id = '0;
    for (int i = NUM_PATTERNS - 1; i >= 0; i--) begin
      if (pend_valid[i]) push_id = 2'(i);
    end
    push  = (pend_valid != '0) && !full;
    grant = '0;
    if (push) grant[push_id] = 1'b1;

    // A slot freed by this edge's push can take a new event without loss.
    new_ev   = {NUM_PATTERNS{enable}} & (match_event | sample_event | merged_event);
    load     = new_ev & (~pend_valid | grant);
    drop_vec = new_ev & pend_valid & ~grant;

    drop_inc = '0;
    for (int i = 0; i < NUM_PATTERNS; i++) begin
      drop_inc = drop_inc + 3'(drop_vec[i]);
    end
    drop_sum = 17'(drop_count) + 17'(drop_inc);

    push_rec = {pend_ts[push_id], pend_type[push_id], 3'b000, push_id, seq,
                pend_data[push_id]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ts          <= '0;
      seq         <= '0;
      pend_valid  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      drop_count  <= '0;
      event_count <= '0;
    end else begin
      ts         <= ts + 32'd1;
      pend_valid <= (pend_valid & ~grant) | load;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase

      // clear wins over same-edge increments; the pushed record already took the old seq.
      if (clear) begin
        seq         <= '0;
        event_count <= '0;
        drop_count  <= '0;
      end else begin
        if (push) begin
          seq         <= seq + 8'd1;
          event_count <= event_count + 32'd1;
        end
        drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PATTERNS; i++) begin
      if (load[i]) begin
        pend_type[i] <= {merged_event[i], sample_event[i], match_event[i]};
        pend_data[i] <= sample_event[i] ? sample_data[48*i +: 48] : 48'h0;
        pend_ts[i]   <= ts;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_rec;
  end

endmodule

// File: tb/tb_sigmon_event_recorder.sv
// Self-checking bench for sigmon_event_recorder: vector table, scoreboard queue
// of expected records, and hand-written multi-cycle sequences.
module tb_sigmon_event_recorder;

  localparam int FIFO_AW = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  logic               clear;
  logic [3:0]         match_event;
  logic [3:0]         sample_event;
  logic [3:0]         merged_event;
  logic [191:0]       sample_data;
  logic               rec_valid;
  logic               rec_ready;
  logic [95:0]        rec_data;
  logic [FIFO_AW:0]   fifo_count;
  logic [15:0]        drop_count;
  logic [31:0]        event_count;

  sigmon_event_recorder #(.FIFO_AW(FIFO_AW), .NUM_PATTERNS(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .match_event(match_event), .sample_event(sample_event),
    .merged_event(merged_event), .sample_data(sample_data),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_data(rec_data),
    .fifo_count(fifo_count), .drop_count(drop_count), .event_count(event_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  logic [31:0] tb_ts;
  always @(posedge clk) begin
    if (reset) tb_ts <= '0;
    else       tb_ts <= tb_ts + 32'd1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [95:0] exp_q[$];
  logic [7:0]  exp_seq = '0;
  int          exp_events = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && rec_valid === 1'b1 && rec_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_record: got %h expected none", rec_data);
      end else begin
        check("record", rec_data, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    match_event  = '0;
    sample_event = '0;
    merged_event = '0;
    clear        = 1'b0;
  endtask

  function automatic logic [191:0] rand192();
    logic [191:0] v;
    for (int w = 0; w < 6; w++) v[32*w +: 32] = $urandom;
    return v;
  endfunction

  task automatic expect_rec(input int id, input logic [2:0] typ, input logic [47:0] data);
    exp_q.push_back({tb_ts, typ, 3'b000, 2'(id), exp_seq, data});
    exp_seq++;
    exp_events++;
  endtask

  // Drive one cycle of events; keep=0 marks events the bench expects to be dropped.
  task automatic fire(input logic [3:0] m, input logic [3:0] s, input logic [3:0] g,
                      input logic [191:0] d, input bit keep);
    match_event  = m;
    sample_event = s;
    merged_event = g;
    sample_data  = d;
    for (int i = 0; i < 4; i++) begin
      if (keep && enable && (m[i] | s[i] | g[i]))
        expect_rec(i, {g[i], s[i], m[i]}, s[i] ? d[48*i +: 48] : 48'h0);
    end
  endtask

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      step();
      n++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    exp_q.delete();
    exp_seq    = '0;
    exp_events = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  unit;
    logic [2:0]  typ;
    logic [47:0] data;
    logic [2:0]  exp_typ;
    logic [47:0] exp_data;
  } vec_t;

  vec_t tbl[6];
  logic [1:0] id_order[3];
  int n_stream;

  initial begin
    tbl[0] = '{2'd0, 3'b110, 48'h1234_5678_9ABC, 3'b110, 48'h1234_5678_9ABC};
    tbl[1] = '{2'd1, 3'b001, 48'hFFFF_FFFF_FFFF, 3'b001, 48'h0};
    tbl[2] = '{2'd2, 3'b010, 48'hA5A5_5A5A_0F0F, 3'b010, 48'hA5A5_5A5A_0F0F};
    tbl[3] = '{2'd3, 3'b111, 48'hFFFF_FFFF_FFFF, 3'b111, 48'hFFFF_FFFF_FFFF};
    tbl[4] = '{2'd3, 3'b100, 48'h0000_DEAD_BEEF, 3'b100, 48'h0};
    tbl[5] = '{2'd1, 3'b011, 48'h0000_0000_0001, 3'b011, 48'h0000_0000_0001};
    id_order[0] = 2'd0;
    id_order[1] = 2'd1;
    id_order[2] = 2'd3;

    reset = 1'b1; enable = 1'b1; rec_ready = 1'b0; sample_data = '0;
    idle();
    do_reset();

    @(negedge clk);
    check("rst_valid",   rec_valid, 0);
    check("rst_count",   fifo_count, 0);
    check("rst_data",    rec_data, 0);
    check("rst_drops",   drop_count, 0);
    check("rst_events",  event_count, 0);

    // Single match on unit 2 at timestamp 0x10, valid for exactly one cycle.
    rec_ready = 1'b1;
    for (int n = 0; n < 40 && tb_ts != 32'h10; n++) step();
    fire(4'b0100, 4'b0000, 4'b0000, rand192(), 1'b1);
    step();
    idle();
    @(negedge clk);
    check("t1_valid_e0", rec_valid, 0);
    step();
    @(negedge clk);
    check("t1_valid_e1", rec_valid, 1);
    check("t1_ts",       rec_data[95:64], 32'h10);
    check("t1_hdr",      rec_data[63:48], 16'h2200);
    step();
    @(negedge clk);
    check("t1_valid_e2", rec_valid, 0);

    // Table of single-unit events with mixed type bits.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      sample_data = rand192();
      sample_data[48*tbl[k].unit +: 48] = tbl[k].data;
      match_event  = '0; match_event[tbl[k].unit]  = tbl[k].typ[0];
      sample_event = '0; sample_event[tbl[k].unit] = tbl[k].typ[1];
      merged_event = '0; merged_event[tbl[k].unit] = tbl[k].typ[2];
      expect_rec(tbl[k].unit, tbl[k].exp_typ, tbl[k].exp_data);
      step();
      idle();
      wait_drain(10);
      check("tbl_events", event_count, exp_events);
      check("tbl_count",  fifo_count, 0);
    end

    // Three units in the same cycle drain in index order on consecutive cycles.
    fire(4'b1011, 4'b0000, 4'b0000, rand192(), 1'b1);
    step();
    idle();
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      check("multi_valid", rec_valid, 1);
      check("multi_id",    rec_data[57:56], id_order[k]);
    end
    wait_drain(10);

    // Fill the FIFO with rec_ready low; slot 1 holds one more, the rest drop.
    rec_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      fire(4'b0010, 4'b0010, 4'b0000, rand192(), k < 17);
      step();
      idle();
      step();
    end
    @(negedge clk);
    check("full_count",  fifo_count, 16);
    check("full_drops",  drop_count, 3);
    check("full_events", event_count, exp_events - 1);
    check("hold_data_a", rec_data, exp_q[0]);
    step();
    @(negedge clk);
    check("hold_data_b", rec_data, exp_q[0]);
    rec_ready = 1'b1;
    wait_drain(40);
    check("drain_count",  fifo_count, 0);
    check("drain_events", event_count, exp_events);

    // Simultaneous push and pop keep the occupancy constant; no drops.
    rec_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      fire(4'b0100, 4'b0000, 4'b0000, rand192(), 1'b1);
      step();
      idle();
      step();
    end
    rec_ready = 1'b1;
    n_stream = $urandom_range(4, 8);
    for (int k = 0; k < n_stream; k++) begin
      fire(4'b0001, 4'b0001, 4'b0000, rand192(), 1'b1);
      step();
      @(negedge clk);
      check("pp_count", fifo_count, 2);
    end
    idle();
    wait_drain(20);
    check("pp_drops", drop_count, 3);

    // clear on the same edge as a push: that record keeps the old seq.
    fire(4'b1000, 4'b0000, 4'b0000, rand192(), 1'b1);
    step();
    idle();
    clear = 1'b1;
    step();
    clear = 1'b0;
    exp_seq    = '0;
    exp_events = 0;
    @(negedge clk);
    check("clr_drops",  drop_count, 0);
    check("clr_events", event_count, 0);
    fire(4'b1000, 4'b1000, 4'b0000, rand192(), 1'b1);
    step();
    idle();
    wait_drain(10);
    check("clr_events_after", event_count, 1);

    // enable low: events ignored entirely.
    enable = 1'b0;
    fire(4'b1111, 4'b1111, 4'b1111, rand192(), 1'b1);
    step();
    fire(4'b0101, 4'b0000, 4'b1010, rand192(), 1'b1);
    step();
    idle();
    step();
    step();
    @(negedge clk);
    check("dis_valid",  rec_valid, 0);
    check("dis_count",  fifo_count, 0);
    check("dis_drops",  drop_count, 0);
    check("dis_events", event_count, 1);

    // Pending slots keep draining after enable drops.
    enable = 1'b1;
    fire(4'b0011, 4'b0001, 4'b0010, rand192(), 1'b1);
    step();
    enable = 1'b0;
    idle();
    wait_drain(10);
    enable = 1'b1;

    // Reset in the middle of a drain discards everything.
    rec_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      fire(4'b0001, 4'b0000, 4'b0000, rand192(), 1'b1);
      step();
      idle();
      step();
    end
    rec_ready = 1'b1;
    step();
    step();
    reset = 1'b1;
    step();
    @(negedge clk);
    check("mid_rst_valid",  rec_valid, 0);
    check("mid_rst_count",  fifo_count, 0);
    check("mid_rst_data",   rec_data, 0);
    check("mid_rst_events", event_count, 0);
    reset = 1'b0;
    exp_q.delete();
    exp_seq    = '0;
    exp_events = 0;
    step();
    fire(4'b0010, 4'b0000, 4'b0000, rand192(), 1'b1);
    step();
    idle();
    wait_drain(10);
    check("post_rst_events", event_count, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sigmon_event_recorder.md
Name: sigmon_event_recorder

Overview:
- Downstream consumer of up to four sigmon pattern units.
- Captures each unit's eop-aligned match/sample/merged pulses together with the 48-bit sample data, a free-running timestamp and a sequence number.
- Queues these as 96-bit records in a first-word-fall-through FIFO drained by a valid/ready stream toward host readout logic.
- Keeps drop and total-event statistics.

Parameters:
- FIFO_AW, 4, log2 of record FIFO depth (depth 16 at default)
- NUM_PATTERNS, 4, number of pattern units. Fixed at 4; pattern id is 2 bits.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  level; when low, incoming events are ignored (not counted, not dropped)
- clear  input  1  single-cycle pulse; zeroes statistics and the sequence number
- match_event  input  4  bit i = match_event_out of pattern unit i
- sample_event  input  4  bit i = sample_event_out of pattern unit i
- merged_event  input  4  bit i = merged_event_out of pattern unit i
- sample_data  input  192  [48i+47:48i] = sample_data_out of unit i
- rec_valid  output  1  record available
- rec_ready  input  1  consumer accepts record
- rec_data  output  96  head record
- fifo_count  output  FIFO_AW+1  current occupancy
- drop_count  output  16  saturating count of lost events
- event_count  output  32  wrapping count of records pushed

Behaviour:
- Reset: timestamp, pending state, FIFO pointers, fifo_count, drop_count, event_count and seq all 0. rec_valid=0. rec_data=0 while the FIFO is empty.
- Timestamp: 32-bit, +1 every cycle, wraps at 2^32. It is not affected by clear.
- Event on unit i (enable=1 and any of match/sample/merged bit i high):
  - At that edge, the pending slot i stores type bits {merged, sample, match}, data, and timestamp.
  - If the sample bit is 0, stored data is 0.
- Arbiter: each cycle, if any slot is pending and fifo_count < 2^FIFO_AW, it pushes the lowest-index pending slot and clears it.
- Record layout:
  - [95:64] timestamp
  - [63] merged, [62] sample, [61] match
  - [60:58] = 0
  - [57:56] pattern id
  - [55:48] seq
  - [47:0] data
- seq increments (8-bit wrap) and event_count increments on every push.
- Latency: event at edge E0 gives rec_valid high after E0+1 at the earliest, when the FIFO is empty and no lower-index slot is pending.
- Slot i pushed and new event i on the same edge: the new event loads the slot. No drop.
- Slot i occupied, not pushed, and a new event i arrives: the new event is discarded, the slot keeps its old content, drop_count += 1 (saturates at 0xFFFF).
- FIFO full: no push. Pending slots are held; further collisions count as drops.
- Pop when rec_valid & rec_ready. Push and pop on the same edge are allowed whenever not full.
- FIFO is FWFT: rec_data always presents the head entry. rec_data is stable while rec_valid=1 and rec_ready=0.
- fifo_count is exact, including simultaneous push and pop.
- clear: on that edge, drop_count=0, event_count=0, seq=0. A push on the same edge still writes a record with the old seq, then seq becomes 0. FIFO contents and pending slots are untouched.
- enable low: pending slots and FIFO keep draining normally.
- Reset mid-operation: all contents are discarded and rec_valid falls after the reset edge.

Test Plan:
- Single match on unit 2 at timestamp 0x10 with rec_ready=1 -> one record: ts=0x10, bits[63:61]=001, id=2, seq=0, data=0. rec_valid high exactly one cycle, at E0+1.
- Sample on unit 0 with data 0x123456789ABC, plus merged on unit 0 the same cycle -> one record: [63:61]=110, data=0x123456789ABC, event_count=1.
- Match on units 0, 1, 3 in the same cycle -> three records on consecutive cycles in order id 0, 1, 3, all with the same timestamp and seq 0, 1, 2.
- rec_ready=0 with 20 single events on unit 1 spaced 2 cycles apart:
  - fifo_count reaches 16 and slot 1 fills.
  - The remaining collisions raise drop_count to 3.
  - Raising rec_ready drains 17 records in seq order 0..16.
- Overlapping clear, enable=0, and reset:
  - clear pulse concurrent with a push -> that record carries the old seq; the next record has seq=0; drop_count=0.
  - enable=0 with events -> no records and no drops.
  - reset mid-drain -> rec_valid=0 and fifo_count=0 on the next cycle.
